// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, decoder encodings, trap causes, status bit positions and FSM states
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;
    localparam logic [2:0] OP_SYS = 3'd0;
    localparam logic [2:0] OP_RW  = 3'd1;
    localparam logic [2:0] OP_RS  = 3'd2;
    localparam logic [2:0] OP_RC  = 3'd3;
    localparam logic [2:0] OP_RWI = 3'd5;
    localparam logic [2:0] OP_RSI = 3'd6;
    localparam logic [2:0] OP_RCI = 3'd7;
    localparam logic [1:0] SYS_ECALL = 2'b00;
    localparam logic [1:0] SYS_WFI   = 2'b10;
    localparam logic [1:0] SYS_MRET  = 2'b11;
    localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
    localparam logic [31:0] MCAUSE_MEI     = 32'h8000_000B;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MEIE     = 11;
    localparam int MIP_MEIP     = 11;
    typedef enum logic {ST_RUN, ST_SLEEP} state_t;
endpackage

// File: rtl/csr_irq_sync.sv
// csr_irq_sync: two-flop synchronizer for the asynchronous external interrupt line
module csr_irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;
    // shift the raw line through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap unit; define CSR_MCYCLE_EN to add the 64-bit mcycle counter
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0010,
    parameter logic [31:0] HART_ID   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [31:0] pc_i,
    input  logic        csr_en,
    input  logic [2:0]  csr_opcode,
    input  logic        csr_data_sel,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  sys_inst,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  zimm,
    input  logic        irq_i,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    output logic [31:0] trap_pc,
    output logic        trap_take,
    output logic        int_en,
    output logic        sleep
);
    state_t      state_q, state_d;
    logic        mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d, meip_q, meip_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic        irq_sync, hit, ro, wr_req, act, irq_take, sys_op, ecall, mret, wfi, wr_en;
    logic [31:0] operand, wdata;
    logic [1:0]  kind;

    csr_irq_sync u_sync (.clk(clk), .rst(rst), .d(irq_i), .q(irq_sync));

`ifdef CSR_MCYCLE_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic        wr_lo, wr_hi;
    assign wr_lo = wr_en && csr_addr == CSR_MCYCLE;
    assign wr_hi = wr_en && csr_addr == CSR_MCYCLEH;
    // free-running counter; a written half takes the write, and a low write kills the carry
    always_comb begin
        mcycle_d = {wr_hi ? wdata : mcycle_q[63:32] + {31'b0, !wr_lo && &mcycle_q[31:0]},
                    wr_lo ? wdata : mcycle_q[31:0] + 32'd1};
    end
    // counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) mcycle_q <= '0;
        else     mcycle_q <= mcycle_d;
    end
`endif

    // old-value read mux; also classifies the address as implemented and/or read-only
    always_comb begin
        hit       = 1'b1;
        ro        = 1'b0;
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE]  = mie_q;
                csr_rdata[MSTATUS_MPIE] = mpie_q;
            end
            CSR_MIE:      csr_rdata[MIE_MEIE] = meie_q;
            CSR_MTVEC:    csr_rdata = mtvec_q;
            CSR_MSCRATCH: csr_rdata = mscratch_q;
            CSR_MEPC:     csr_rdata = mepc_q;
            CSR_MCAUSE:   csr_rdata = mcause_q;
            CSR_MIP: begin
                csr_rdata[MIP_MEIP] = meip_q;
                ro = 1'b1;
            end
            CSR_MHARTID: begin
                csr_rdata = HART_ID;
                ro = 1'b1;
            end
`ifdef CSR_MCYCLE_EN
            CSR_MCYCLE:  csr_rdata = mcycle_q[31:0];
            CSR_MCYCLEH: csr_rdata = mcycle_q[63:32];
`else
            CSR_MCYCLE, CSR_MCYCLEH: csr_rdata = '0;
`endif
            default: hit = 1'b0;
        endcase
    end

    assign operand  = csr_data_sel ? {27'b0, zimm} : rs1_data;
    assign kind     = csr_opcode[1:0];
    assign wr_req   = csr_en && csr_opcode != OP_SYS && (kind == 2'b01 || (kind[1] && operand != '0));
    assign wdata    = kind == 2'b01 ? operand : kind == 2'b10 ? csr_rdata | operand : csr_rdata & ~operand;
    assign act      = instr_valid && state_q == ST_RUN;
    assign int_en   = mie_q && meie_q && meip_q;
    assign irq_take = act && int_en;
    assign sys_op   = act && !int_en && csr_en && csr_opcode == OP_SYS;
    assign ecall    = sys_op && sys_inst == SYS_ECALL;
    assign mret     = sys_op && sys_inst == SYS_MRET;
    assign wfi      = sys_op && sys_inst == SYS_WFI;
    assign wr_en    = act && !int_en && wr_req && hit && !ro;
    assign csr_illegal = csr_en && csr_opcode != OP_SYS && (!hit || (ro && wr_req));
    assign trap_take   = irq_take || ecall || mret;
    assign trap_pc     = mret ? mepc_q : mtvec_q;
    assign sleep       = state_q == ST_SLEEP;

    // next CSR state: software writes, then trap entry / return, plus the sleep FSM
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        meip_d     = irq_sync;
        if (wr_en) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = wdata[MSTATUS_MIE];
                    mpie_d = wdata[MSTATUS_MPIE];
                end
                CSR_MIE:      meie_d = wdata[MIE_MEIE];
                CSR_MTVEC:    mtvec_d = wdata & ~32'h3;
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d = wdata & ~32'h3;
                CSR_MCAUSE:   mcause_d = wdata;
                default: ;
            endcase
        end
        if (irq_take || ecall) begin
            mepc_d   = pc_i & ~32'h3;
            mcause_d = irq_take ? MCAUSE_MEI : MCAUSE_ECALL_M;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
        if (mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        state_d = state_q == ST_RUN ? (wfi ? ST_SLEEP : ST_RUN)
                                    : (meip_q && meie_q ? ST_RUN : ST_SLEEP);
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            meip_q     <= 1'b0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            meip_q     <= meip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: randomized scoreboard bench for csr_unit against a behavioural CSR model
module tb_csr_unit;
    logic        clk = 1'b0, rst = 1'b1, instr_valid = 1'b0, csr_en = 1'b0, csr_data_sel = 1'b0, irq_i = 1'b0;
    logic [31:0] pc_i = '0, rs1_data = '0;
    logic [2:0]  csr_opcode = '0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  sys_inst = '0;
    logic [4:0]  zimm = '0;
    logic [31:0] csr_rdata, trap_pc;
    logic        csr_illegal, trap_take, int_en, sleep;

    csr_unit dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_i(pc_i), .csr_en(csr_en),
        .csr_opcode(csr_opcode), .csr_data_sel(csr_data_sel), .csr_addr(csr_addr),
        .sys_inst(sys_inst), .rs1_data(rs1_data), .zimm(zimm), .irq_i(irq_i),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .trap_pc(trap_pc),
        .trap_take(trap_take), .int_en(int_en), .sleep(sleep)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        illegal;
        logic        take;
        logic [31:0] tpc;
        logic        inten;
        logic        slp;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0, total = 0, txn = 0;

    logic        m_mie, m_mpie, m_meie, m_meip, m_sleep;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic        irq_hist[$];
`ifdef CSR_MCYCLE_EN
    logic [63:0] m_cyc;
`endif

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; m_meie = 0; m_meip = 0; m_sleep = 0;
        m_mtvec = 32'h10; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        irq_hist = '{1'b0, 1'b0, 1'b0};
`ifdef CSR_MCYCLE_EN
        m_cyc = 0;
`endif
    endfunction

    function automatic void mread(input logic [11:0] a, output logic [31:0] v, output logic ok, output logic ro);
        ok = 1; ro = 0; v = 0;
        case (a)
            12'h300: v = {24'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h304: v = {20'b0, m_meie, 11'b0};
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h344: begin v = {20'b0, m_meip, 11'b0}; ro = 1; end
            12'hF14: ro = 1;
`ifdef CSR_MCYCLE_EN
            12'hB00: v = m_cyc[31:0];
            12'hB80: v = m_cyc[63:32];
`else
            12'hB00, 12'hB80: v = 0;
`endif
            default: ok = 0;
        endcase
    endfunction

    // expected outputs for the current inputs, plus what the coming edge should commit
    task automatic calc(output exp_t e, output logic wr, output logic [31:0] nv,
                        output logic t_irq, output logic t_ecall, output logic t_mret, output logic t_wfi);
        logic [31:0] v, opnd;
        logic ok, ro, inten, live, sysop;
        mread(csr_addr, v, ok, ro);
        opnd = csr_data_sel ? {27'b0, zimm} : rs1_data;
        wr = csr_en && csr_opcode != 0 && (csr_opcode[1:0] == 2'd1 || opnd != 0);
        case (csr_opcode[1:0])
            2'd1:    nv = opnd;
            2'd2:    nv = v | opnd;
            default: nv = v & ~opnd;
        endcase
        inten   = m_mie && m_meie && m_meip;
        live    = instr_valid && !m_sleep;
        sysop   = live && !inten && csr_en && csr_opcode == 0;
        t_irq   = live && inten;
        t_ecall = sysop && sys_inst == 2'b00;
        t_mret  = sysop && sys_inst == 2'b11;
        t_wfi   = sysop && sys_inst == 2'b10;
        e.id      = txn;
        e.rdata   = v;
        e.illegal = csr_en && csr_opcode != 0 && (!ok || (ro && wr));
        e.take    = t_irq || t_ecall || t_mret;
        e.tpc     = t_mret ? m_mepc : m_mtvec;
        e.inten   = inten;
        e.slp     = m_sleep;
        wr = wr && live && !inten && ok && !ro;
    endtask

    task automatic commit();
        exp_t e;
        logic wr, ti, te, tm, tw, wake;
        logic [31:0] nv;
        if (rst) begin
            model_reset();
            return;
        end
        calc(e, wr, nv, ti, te, tm, tw);
        wake = m_sleep && m_meip && m_meie;
`ifdef CSR_MCYCLE_EN
        if (wr && csr_addr == 12'hB00)      m_cyc = {m_cyc[63:32], nv};
        else if (wr && csr_addr == 12'hB80) m_cyc = {nv, m_cyc[31:0] + 32'd1};
        else                                m_cyc = m_cyc + 64'd1;
`endif
        if (ti || te) begin
            m_mepc   = pc_i & ~32'h3;
            m_mcause = ti ? 32'h8000_000B : 32'h0000_000B;
            m_mpie   = m_mie;
            m_mie    = 0;
        end
        if (tm) begin
            m_mie  = m_mpie;
            m_mpie = 1;
        end
        if (tw) m_sleep = 1;
        else if (wake) m_sleep = 0;
        if (wr) begin
            case (csr_addr)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: m_meie = nv[11];
                12'h305: m_mtvec = nv & ~32'h3;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                default: ;
            endcase
        end
        irq_hist.push_back(irq_i);
        void'(irq_hist.pop_front());
        m_meip = irq_hist[0];
    endtask

    task automatic push_expect();
        exp_t e;
        logic wr, a, b, c, d;
        logic [31:0] nv;
        calc(e, wr, nv, a, b, c, d);
        sbq.push_back(e);
        txn++;
    endtask

    task automatic drive(input logic iv, input logic en, input logic [2:0] op, input logic sel,
                         input logic [11:0] a, input logic [1:0] si, input logic [31:0] r,
                         input logic [4:0] z, input logic [31:0] pc, input logic irq);
        @(posedge clk);
        commit();
        #1;
        rst = 0; instr_valid = iv; csr_en = en; csr_opcode = op; csr_data_sel = sel;
        csr_addr = a; sys_inst = si; rs1_data = r; zimm = z; pc_i = pc; irq_i = irq;
        push_expect();
    endtask

    task automatic do_reset(input logic [11:0] a);
        @(posedge clk);
        commit();
        #1;
        rst = 1; instr_valid = 0; csr_en = 0; csr_opcode = 0; csr_addr = a; irq_i = 0;
        model_reset();
        push_expect();
    endtask

    task automatic inst(input logic [2:0] op, input logic sel, input logic [11:0] a,
                        input logic [31:0] r, input logic [4:0] z, input logic [31:0] pc);
        drive(1, 1, op, sel, a, 2'b00, r, z, pc, irq_i);
    endtask

    task automatic sys(input logic [1:0] si, input logic [31:0] pc);
        drive(1, 1, 3'd0, 0, 12'h000, si, 0, 0, pc, irq_i);
    endtask

    task automatic idle(input logic [11:0] a, input logic irq);
        drive(0, 0, 3'd0, 0, a, 2'b00, 0, 0, 0, irq);
    endtask

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s txn%0d: got %h expected %h", name, id, got, exp);
    endtask

    // monitor: every presented cycle is compared against the oldest scoreboard entry
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("csr_rdata", e.id, csr_rdata, e.rdata);
                chk("csr_illegal", e.id, {31'b0, csr_illegal}, {31'b0, e.illegal});
                chk("trap_take", e.id, {31'b0, trap_take}, {31'b0, e.take});
                if (e.take) chk("trap_pc", e.id, trap_pc, e.tpc);
                chk("int_en", e.id, {31'b0, int_en}, {31'b0, e.inten});
                chk("sleep", e.id, {31'b0, sleep}, {31'b0, e.slp});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ops [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
        logic [11:0] addrs [12] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h344, 12'hF14, 12'hB00, 12'hB80, 12'hABC, 12'h7C0};
        logic [1:0]  sis [3] = '{2'b00, 2'b10, 2'b11};
        int slept = 0;
        model_reset();
        do_reset(12'h305);
        do_reset(12'h300);
        // scratch read-modify-write
        inst(3'd1, 0, 12'h340, 32'hDEAD_BEEF, 0, 32'h40);
        inst(3'd6, 1, 12'h340, 0, 5'd3, 32'h44);
        idle(12'h340, 0);
        // ECALL then MRET
        inst(3'd1, 0, 12'h305, 32'h200, 0, 32'h48);
        inst(3'd6, 1, 12'h300, 0, 5'd8, 32'h4C);
        sys(2'b00, 32'h100);
        idle(12'h341, 0);
        idle(12'h342, 0);
        idle(12'h300, 0);
        sys(2'b11, 32'h200);
        idle(12'h300, 0);
        // external interrupt with a concurrent scratch write
        inst(3'd2, 0, 12'h304, 32'h800, 0, 32'h104);
        for (int i = 0; i < 4; i++) idle(12'h344, 1);
        inst(3'd1, 0, 12'h340, 32'h1234_5678, 0, 32'h444);
        idle(12'h340, 1);
        idle(12'h342, 1);
        idle(12'h341, 1);
        for (int i = 0; i < 4; i++) idle(12'h300, 0);
        // WFI sleep and wake with MIE clear
        sys(2'b10, 32'h500);
        idle(12'h300, 0);
        idle(12'h300, 0);
        for (int i = 0; i < 5; i++) idle(12'h344, 1);
        for (int i = 0; i < 4; i++) idle(12'h300, 0);
        // illegal and read-only accesses
        inst(3'd1, 0, 12'hABC, 32'hFFFF_FFFF, 0, 32'h600);
        inst(3'd1, 0, 12'hF14, 32'h5, 0, 32'h604);
        inst(3'd1, 0, 12'h344, 32'h800, 0, 32'h608);
        // reset in the middle of sleep
        sys(2'b10, 32'h700);
        idle(12'h305, 0);
        do_reset(12'h305);
        idle(12'h305, 0);
        // cycle counter wrap of the low half
        inst(3'd1, 0, 12'hB00, 32'hFFFF_FFFF, 0, 32'h800);
        idle(12'hB00, 0);
        idle(12'hB80, 0);
        idle(12'hB00, 0);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic irq;
            irq = ($urandom_range(0, 9) == 0) ? ~irq_i : irq_i;
            if (m_sleep) begin
                slept++;
                if (slept > 25) begin
                    do_reset(addrs[$urandom_range(0, 11)]);
                    slept = 0;
                end else idle(addrs[$urandom_range(0, 11)], ($urandom_range(0, 3) == 0) ? 1'b1 : irq);
            end else begin
                slept = 0;
                if ($urandom_range(0, 7) == 0)
                    drive($urandom_range(0, 3) != 0, 1, 3'd0, 0, addrs[$urandom_range(0, 11)],
                          sis[$urandom_range(0, 2)], 0, 0, $urandom, irq);
                else
                    drive($urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0, ops[$urandom_range(0, 5)],
                          1'($urandom_range(0, 1)), addrs[$urandom_range(0, 11)], 2'b00,
                          ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom, 5'($urandom_range(0, 31)), $urandom, irq);
            end
        end
        idle(12'h300, 0);
        repeat (2) @(posedge clk);
        #1;
        if (sbq.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
